stopwatch_time_counter: RTL

//  Core timebase of the FPGA stopwatch. Divides the system clock into a 1 s tick and keeps a

---
 rtl/stopwatch_time_counter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/stopwatch_time_counter.sv
// Stopwatch timebase: divides clk into a one-second tick and keeps a mm:ss count
// (00:00..59:59) with start/stop, lap-freeze and synchronous clear control.
module stopwatch_time_counter #(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned PRE_W    = 27
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic       running,
    output logic       lap_active,
    output logic       wrap
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } state_t;

    localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(TICK_DIV - 32'd1);
    localparam logic [PRE_W-1:0] PRE_ZERO  = {PRE_W{1'b0}};
    localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(32'd1);
    localparam logic [5:0]       LAST_UNIT = 6'd59;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [5:0]       sec_q, sec_d;
    logic [5:0]       min_q, min_d;
    logic [5:0]       out_sec_q, out_sec_d;
    logic [5:0]       out_min_q, out_min_d;
    logic             running_q, running_d;
    logic             lap_active_q, lap_active_d;
    logic             wrap_q, wrap_d;
    logic             ss_prev_q;
    logic             lap_prev_q;
    logic             start_edge_s;
    logic             lap_edge_s;
    logic             tick_s;

    // Next-state logic: clear dominates, then run/pause control, lap freeze and the tick.
    always_comb begin
        start_edge_s = start_stop & ~ss_prev_q;
        lap_edge_s   = lap & ~lap_prev_q;
        tick_s       = (state_q == ST_RUNNING) && (pre_q == PRE_MAX);
        state_d      = state_q;
        pre_d        = pre_q;
        sec_d        = sec_q;
        min_d        = min_q;
        out_sec_d    = out_sec_q;
        out_min_d    = out_min_q;
        lap_active_d = lap_active_q;
        wrap_d       = 1'b0;

        if (clear) begin
            state_d      = ST_IDLE;
            pre_d        = PRE_ZERO;
            sec_d        = 6'd0;
            min_d        = 6'd0;
            out_sec_d    = 6'd0;
            out_min_d    = 6'd0;
            lap_active_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = start_edge_s ? ST_RUNNING : ST_IDLE;
                ST_RUNNING: state_d = start_edge_s ? ST_PAUSED  : ST_RUNNING;
                ST_PAUSED:  state_d = start_edge_s ? ST_RUNNING : ST_PAUSED;
                default:    state_d = ST_IDLE;
            endcase

            // A pause edge freezes the partial second unless it lands on the tick itself.
            if (state_q == ST_RUNNING) begin
                if (tick_s) begin
                    pre_d = PRE_ZERO;
                end else if (!start_edge_s) begin
                    pre_d = pre_q + PRE_ONE;
                end else begin
                    pre_d = pre_q;
                end
            end else if (state_q == ST_IDLE) begin
                pre_d = PRE_ZERO;
            end else begin
                pre_d = pre_q;
            end

            if (tick_s) begin
                if (sec_q == LAST_UNIT) begin
                    sec_d = 6'd0;
                    if (min_q == LAST_UNIT) begin
                        min_d  = 6'd0;
                        wrap_d = 1'b1;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                sec_d = sec_q;
                min_d = min_q;
            end

            if (lap_edge_s && (state_q != ST_IDLE)) begin
                lap_active_d = ~lap_active_q;
            end else begin
                lap_active_d = lap_active_q;
            end

            // While frozen the display keeps the pre-tick value; otherwise it tracks live count.
            if (lap_active_d) begin
                out_sec_d = out_sec_q;
                out_min_d = out_min_q;
            end else begin
                out_sec_d = sec_d;
                out_min_d = min_d;
            end
        end

        running_d = (state_d == ST_RUNNING);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pre_q        <= PRE_ZERO;
            sec_q        <= 6'd0;
            min_q        <= 6'd0;
            out_sec_q    <= 6'd0;
            out_min_q    <= 6'd0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
            wrap_q       <= 1'b0;
            ss_prev_q    <= 1'b0;
            lap_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            sec_q        <= sec_d;
            min_q        <= min_d;
            out_sec_q    <= out_sec_d;
            out_min_q    <= out_min_d;
            running_q    <= running_d;
            lap_active_q <= lap_active_d;
            wrap_q       <= wrap_d;
            ss_prev_q    <= start_stop;
            lap_prev_q   <= lap;
        end
    end

    assign seconds    = out_sec_q;
    assign minutes    = out_min_q;
    assign running    = running_q;
    assign lap_active = lap_active_q;
    assign wrap       = wrap_q;

endmodule
